// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller and the PC register.
package fetch_ctrl_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_EXEC  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_t;

    // Fault codes reported on o_fault_code
    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_BUSERR   = 2'd2;
    localparam logic [1:0] FLT_TIMEOUT  = 2'd3;

    // NOP (addi x0, x0, 0) shown to decode whenever no instruction is live
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Reset value of the PC register feeding this controller
    localparam logic [31:0] PC_RESET = 32'h0000_0064;

    // Instruction fetches must be word aligned
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Saturating wait-state counter with synchronous clear and terminal-count flag.
module fetch_timeout_cnt #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count_reg;

    // Count enabled cycles, holding at the terminal value instead of wrapping
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            count_reg <= '0;
        end else if (i_en && (count_reg != TC_VAL)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign o_tc = (count_reg == TC_VAL);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: requests the word at i_pc, waits for memory, presents the
// instruction for one cycle and pulses the PC enable once per retired fetch.
// Misaligned PCs, bus errors and timeouts park the controller in a sticky fault.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc,
    input  logic        i_halt,
    output logic        o_pc_clk_enable,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_err,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    output logic        o_fault,
    output logic [1:0]  o_fault_code
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    fetch_state_t state_reg, state_next;
    logic [1:0]   fault_code_reg, fault_code_next;
    logic [31:0]  instr_reg, instr_next;

    logic imem_req;
    logic instr_valid;
    logic pc_en;
    logic fault;
    logic cnt_en;
    logic cnt_clr;
    logic cnt_tc;

    // Wait-state counter; only runs while a request is outstanding
    fetch_timeout_cnt #(
        .WIDTH    (CNT_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timeout_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (cnt_clr),
        .i_en  (cnt_en),
        .o_tc  (cnt_tc)
    );

    // State, fault code and fetched word registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= S_IDLE;
            fault_code_reg <= FLT_NONE;
            instr_reg      <= NOP_INSTR;
        end else begin
            state_reg      <= state_next;
            fault_code_reg <= fault_code_next;
            instr_reg      <= instr_next;
        end
    end

    // Next-state and output decode; err beats data, ack beats timeout
    always_comb begin
        state_next      = state_reg;
        fault_code_next = fault_code_reg;
        instr_next      = instr_reg;
        imem_req        = 1'b0;
        instr_valid     = 1'b0;
        pc_en           = 1'b0;
        fault           = 1'b0;
        cnt_en          = 1'b0;
        cnt_clr         = 1'b1;
        unique case (state_reg)
            S_IDLE: begin
                if (!i_halt) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                cnt_clr = 1'b0;
                if (pc_misaligned(i_pc)) begin
                    state_next      = S_FAULT;
                    fault_code_next = FLT_MISALIGN;
                end else begin
                    imem_req = 1'b1;
                    if (i_imem_ack) begin
                        if (i_imem_err) begin
                            state_next      = S_FAULT;
                            fault_code_next = FLT_BUSERR;
                        end else begin
                            instr_next = i_imem_rdata;
                            state_next = S_EXEC;
                        end
                    end else if (cnt_tc) begin
                        state_next      = S_FAULT;
                        fault_code_next = FLT_TIMEOUT;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                pc_en       = 1'b1;
                state_next  = i_halt ? S_IDLE : S_REQ;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
        endcase
    end

    assign o_imem_req      = imem_req;
    assign o_imem_addr     = i_pc;
    assign o_instr_valid   = instr_valid;
    assign o_instr         = instr_valid ? instr_reg : NOP_INSTR;
    assign o_pc_clk_enable = pc_en;
    assign o_fault         = fault;
    assign o_fault_code    = fault_code_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl. The driver plays PC register and
// instruction memory and predicts, from the fetch rules, when each request,
// retirement and fault must appear; the monitor pops and compares as the DUT
// presents them.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int          TO  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int EV_REQ     = 0;
    localparam int EV_REQ_END = 1;
    localparam int EV_INSTR   = 2;
    localparam int EV_FAULT   = 3;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_pc;
    logic        i_halt = 1'b0;
    logic        o_pc_clk_enable;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic        i_imem_err = 1'b0;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic        o_fault;
    logic [1:0]  o_fault_code;

    logic [31:0] pc_reg = PC_RESET;
    logic        pc_force = 1'b0;
    logic [31:0] pc_force_val = 32'h0;
    int          cyc = 0;
    logic        rst_q = 1'b0;
    bit          done = 1'b0;

    // driver-side reference model state
    int          next_req = 0;
    logic [31:0] pc_model = 32'h64;

    // monitor state
    int   n_checks = 0;
    int   n_pass = 0;
    logic req_prev = 1'b0;
    logic fault_prev = 1'b0;
    logic faulted = 1'b0;
    logic [1:0] fault_snap = 2'd0;

    fetch_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .NOP_INSTR      (NOP)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_pc            (i_pc),
        .i_halt          (i_halt),
        .o_pc_clk_enable (o_pc_clk_enable),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_ack      (i_imem_ack),
        .i_imem_rdata    (i_imem_rdata),
        .i_imem_err      (i_imem_err),
        .o_instr         (o_instr),
        .o_instr_valid   (o_instr_valid),
        .o_fault         (o_fault),
        .o_fault_code    (o_fault_code)
    );

    always #5 i_clk = ~i_clk;

    // cycle counter, reset history and the PC register the controller drives
    always @(posedge i_clk) begin
        cyc   <= cyc + 1;
        rst_q <= i_rst;
        if (i_rst) pc_reg <= PC_RESET;
        else if (o_pc_clk_enable) pc_reg <= pc_reg + 32'd4;
    end

    assign i_pc = pc_force ? pc_force_val : pc_reg;

    // ---------------- monitor / scoreboard ----------------
    function automatic string kname(input int k);
        case (k)
            EV_REQ:     return "req_start";
            EV_REQ_END: return "req_end";
            EV_INSTR:   return "instr_retire";
            default:    return "fault_entry";
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, required %h", nm, cyc, act, req);
    endtask

    task automatic present(input int kind, input logic [31:0] val);
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s at cycle %0d: got unexpected event val %h, required no event",
                     kname(kind), cyc, val);
        end else if (exp_q[0].kind != kind || exp_q[0].cyc != cyc || exp_q[0].val !== val) begin
            $display("FAIL %s at cycle %0d: got val %h, required %s at cycle %0d val %h",
                     kname(kind), cyc, val, kname(exp_q[0].kind), exp_q[0].cyc, exp_q[0].val);
            if (exp_q[0].kind == kind) exp_q.delete(0);
        end else begin
            $display("ok %s at cycle %0d val %h", kname(kind), cyc, val);
            n_pass++;
            exp_q.delete(0);
        end
    endtask

    // compare the DUT against the scoreboard once per cycle, away from the edge
    always @(negedge i_clk) begin
        if (cyc >= 1) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++;
                $display("FAIL %s missing: required at cycle %0d val %h, not seen by cycle %0d",
                         kname(exp_q[0].kind), exp_q[0].cyc, exp_q[0].val, cyc);
                exp_q.delete(0);
            end
            if (rst_q) begin
                chk("reset_outputs", 64'({o_imem_req, o_instr_valid, o_pc_clk_enable, o_fault, o_fault_code}), 64'd0);
                chk("reset_instr", 64'(o_instr), 64'(NOP));
                faulted = 1'b0;
            end
            if (!o_imem_req && req_prev) present(EV_REQ_END, 32'h0);
            if (o_imem_req && !req_prev) present(EV_REQ, o_imem_addr);
            if (o_instr_valid) present(EV_INSTR, o_instr);
            if (o_fault && !fault_prev) begin
                present(EV_FAULT, {30'b0, o_fault_code});
                faulted    = 1'b1;
                fault_snap = o_fault_code;
            end
            chk("pc_en_eq_valid", 64'(o_pc_clk_enable), 64'(o_instr_valid));
            if (!o_instr_valid) chk("instr_nop", 64'(o_instr), 64'(NOP));
            chk("addr_eq_pc", 64'(o_imem_addr), 64'(i_pc));
            if (!o_fault) chk("code_zero", 64'(o_fault_code), 64'd0);
            if (faulted && !rst_q)
                chk("fault_sticky", 64'({o_fault, o_fault_code, o_imem_req, o_instr_valid, o_pc_clk_enable}),
                    64'({1'b1, fault_snap, 3'b000}));
            req_prev   = o_imem_req;
            fault_prev = o_fault;
            if (done) begin
                n_checks++;
                if (exp_q.size() == 0) n_pass++;
                else $display("FAIL queue_drain: got %0d pending events, required 0", exp_q.size());
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end
        end
    end

    // ---------------- driver: PC/memory environment + reference model ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic push(input int c, input int k, input logic [31:0] v);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int hold);
        i_rst = 1'b1;
        i_imem_ack = 1'b0;
        i_imem_err = 1'b0;
        i_halt = 1'b0;
        pc_force = 1'b0;
        repeat (hold) step();
        i_rst = 1'b0;
        pc_model = 32'h64;
        next_req = cyc + 1;          // one idle cycle, then the request
    endtask

    // w >= 0: ack on the (w+1)-th request cycle; w < 0: never ack (timeout)
    task automatic fetch(input int w, input logic [31:0] d, input bit e,
                         input bit halt_after, input int idle_len);
        int s;
        s = next_req;
        push(s, EV_REQ, pc_model);
        if (w < 0) begin
            for (int i = 0; i < TO; i++) begin
                wait_until(s + i);
                i_imem_ack   = 1'b0;
                i_imem_err   = 1'($urandom);
                i_imem_rdata = $urandom;
                i_halt       = 1'($urandom);
            end
            push(s + TO, EV_REQ_END, 32'h0);
            push(s + TO, EV_FAULT, 32'(FLT_TIMEOUT));
            wait_until(s + TO);
            i_halt = 1'b0;
            return;
        end
        for (int i = 0; i <= w; i++) begin
            wait_until(s + i);
            i_halt = 1'($urandom);   // must be ignored while the fetch is outstanding
            if (i == w) begin
                i_imem_ack = 1'b1; i_imem_rdata = d; i_imem_err = e;
            end else begin
                i_imem_ack = 1'b0; i_imem_rdata = $urandom; i_imem_err = 1'($urandom);
            end
        end
        push(s + w + 1, EV_REQ_END, 32'h0);
        if (e) push(s + w + 1, EV_FAULT, 32'(FLT_BUSERR));
        else begin
            push(s + w + 1, EV_INSTR, d);
            pc_model = pc_model + 32'd4;
        end
        wait_until(s + w + 1);
        i_imem_ack = 1'b0;
        i_imem_err = 1'b0;
        if (e) begin
            i_halt = 1'b0;
            return;
        end
        i_halt = halt_after;
        if (!halt_after) next_req = s + w + 2;
        else begin
            repeat (idle_len) step();
            i_halt = 1'b0;
            next_req = cyc + 1;
        end
    endtask

    task automatic misalign_fetch(input int off);
        int s;
        s = next_req;
        pc_force_val = pc_model + 32'(off);
        pc_force = 1'b1;
        push(s + 1, EV_FAULT, 32'(FLT_MISALIGN));
        wait_until(s + 1);
    endtask

    task automatic abort_fetch(input int k);
        int s;
        s = next_req;
        push(s, EV_REQ, pc_model);
        for (int i = 0; i < k; i++) begin
            wait_until(s + i);
            i_imem_ack = 1'b0;
            i_halt = 1'($urandom);
        end
        wait_until(s + k);
        push(s + k + 1, EV_REQ_END, 32'h0);
        do_reset(2);
    endtask

    task automatic linger(input int n);
        repeat (n) begin
            step();
            i_imem_ack = 1'b0;
            i_halt = 1'($urandom);
        end
    endtask

    initial begin
        step();
        do_reset(3);
        // zero-wait fetch, 3 wait states, then bus error at 0x6C
        fetch(0, 32'h00500093, 1'b0, 1'b0, 1);
        fetch(3, $urandom, 1'b0, 1'b0, 1);
        fetch(1, $urandom, 1'b1, 1'b0, 1);
        linger(6);
        do_reset(2);
        // timeout with no ack
        fetch(2, $urandom, 1'b0, 1'b0, 1);
        fetch(-1, 32'h0, 1'b0, 1'b0, 1);
        linger(5);
        do_reset(1);
        // ack on the last allowed cycle, halt, reset mid-request
        fetch(TO - 1, $urandom, 1'b0, 1'b0, 1);
        fetch(0, $urandom, 1'b0, 1'b0, 1);
        fetch(2, $urandom, 1'b0, 1'b1, 3);
        fetch(1, $urandom, 1'b0, 1'b0, 1);
        abort_fetch(2);
        fetch(0, $urandom, 1'b0, 1'b0, 1);
        fetch(4, $urandom, 1'b0, 1'b0, 1);
        // misaligned PC 0x66
        do_reset(2);
        misalign_fetch(2);
        linger(5);
        // random episodes, each ending in a fault
        for (int ep = 0; ep < 8; ep++) begin
            int r;
            do_reset(int'($urandom_range(1, 3)));
            for (int k = 0; k < int'($urandom_range(2, 6)); k++)
                fetch(int'($urandom_range(0, 5)), $urandom, 1'b0,
                      ($urandom_range(0, 3) == 0), int'($urandom_range(1, 3)));
            r = int'($urandom_range(0, 3));
            if (r == 3) begin
                abort_fetch(int'($urandom_range(0, 4)));
                fetch(int'($urandom_range(0, 3)), $urandom, 1'b0, 1'b0, 1);
                fetch(int'($urandom_range(0, 3)), $urandom, 1'b1, 1'b0, 1);
            end else if (r == 2) begin
                misalign_fetch(int'($urandom_range(1, 3)));
            end else if (r == 1) begin
                fetch(-1, 32'h0, 1'b0, 1'b0, 1);
            end else begin
                fetch(int'($urandom_range(0, 5)), $urandom, 1'b1, 1'b0, 1);
            end
            linger(4);
        end
        done = 1'b1;
    end

    // bound the whole run
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by cycle %0d, required completion", cyc);
        $fatal(1, "run did not complete");
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch controller placed directly downstream of the program counter register in the single-cycle data path. It consumes the current PC and issues a request to instruction memory, which may add wait states. It then presents the returned instruction to decode/execute for exactly one cycle and drives the PC clock-enable so the PC advances only once per retired instruction. Misaligned fetches, bus errors and memory timeouts are caught in a sticky fault state.

Parameters:
TIMEOUT_CYCLES, 16, cycles of outstanding request without ack before timeout fault (>=2)
NOP_INSTR, 32'h00000013, value driven on o_instr whenever o_instr_valid is low

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst  input  1  reset, synchronous, active-high
i_pc  input  32  current PC from PC register (resets to 32'h64)
i_halt  input  1  stop issuing new fetches after the current one completes
o_pc_clk_enable  output  1  clock enable to PC register; 1-cycle pulse per retired instruction
o_imem_req  output  1  instruction memory request, level, held until ack
o_imem_addr  output  32  fetch address, equals i_pc while o_imem_req=1
i_imem_ack  input  1  memory ack; valid only while o_imem_req=1
i_imem_rdata  input  32  instruction word, valid with ack
i_imem_err  input  1  bus error, qualified by ack
o_instr  output  32  instruction to decode
o_instr_valid  output  1  o_instr is live this cycle
o_fault  output  1  sticky fault flag
o_fault_code  output  2  0 none, 1 misaligned, 2 bus error, 3 timeout

Behaviour:
- Reset (i_rst=1 at clock edge): state S_IDLE; all outputs 0 except o_instr=NOP_INSTR; timeout counter 0; fault cleared. Reset during an outstanding request abandons it: o_imem_req drops the next cycle, and memory must tolerate this.
- States: S_IDLE, S_REQ, S_EXEC, S_FAULT.
- S_IDLE: no outputs asserted. Next state is S_REQ if i_halt=0, otherwise stay in S_IDLE.
- S_REQ:
  - If i_pc[1:0]!=0: o_imem_req stays 0, next state S_FAULT, code 1.
  - Otherwise o_imem_req=1 and o_imem_addr=i_pc. The counter increments each cycle without ack.
  - ack=1, err=0: latch i_imem_rdata, next state S_EXEC.
  - ack=1, err=1: next state S_FAULT, code 2. err has priority over data.
  - No ack and counter=TIMEOUT_CYCLES-1: next state S_FAULT, code 3.
  - An ack arriving in the same cycle as the timeout threshold wins; no timeout is taken.
  - i_halt is ignored in this state; the outstanding fetch always completes.
- S_EXEC: o_instr_valid=1, o_instr=latched word, o_pc_clk_enable=1 for exactly this cycle. The counter clears. Next state is S_REQ if i_halt=0, otherwise S_IDLE. The PC updates at the end of this cycle, so the next S_REQ sees the new i_pc.
- S_FAULT: o_fault=1 and o_fault_code held. No request, no valid, no PC enable. Only i_rst exits this state.
- Latency: a zero-wait-state memory (ack in the first S_REQ cycle) gives an instruction valid the following cycle. Throughput is 1 instruction per 2 cycles; each wait state adds 1 cycle.
- o_imem_addr is driven as i_pc at all times. Memory samples it only while req=1.
- o_pc_clk_enable is never asserted outside S_EXEC. The PC never advances on a faulted fetch.
- Counter width is clog2(TIMEOUT_CYCLES) bits and saturates, with no wrap.

Decomposition:
- Shared package holds:
  - state encoding (2-bit localparams S_IDLE=0, S_REQ=1, S_EXEC=2, S_FAULT=3)
  - fault code localparams FLT_NONE/MISALIGN/BUSERR/TIMEOUT
  - NOP_INSTR
  - PC reset constant 32'h64, shared with the PC register
- One natural sub-module: fetch_timeout_cnt, a clear/enable saturating counter with a terminal-count output. Everything else stays in fetch_ctrl.

Test Plan:
- Reset then zero-wait memory at i_pc=32'h64, rdata=32'h00500093 -> req at cycle 1; instr_valid and pc_clk_enable at cycle 2 with o_instr=32'h00500093; next req with addr 32'h68 at cycle 3.
- Memory with 3 wait states -> req held for 4 cycles with addr stable; single pc_clk_enable pulse; no fault.
- ack with err=1 at addr 32'h6C -> o_fault=1, code 2, no pc_clk_enable, req low thereafter until reset.
- No ack, TIMEOUT_CYCLES=16 -> fault code 3 after the 16th req cycle. A second run with ack exactly on the 16th cycle -> normal retire, no fault.
- i_pc=32'h66 -> no req ever asserted, fault code 1 the cycle after entering S_REQ.
- i_halt raised mid-request -> current instruction retires, then S_IDLE with no req. i_rst pulsed mid-request -> req drops the next cycle and fetch restarts cleanly.
